// File: rtl/stopwatch_core_if.sv
// Key-strobe / display bundle between the key conditioner, the stopwatch core
// and the per-digit 7-segment decoders.
interface stopwatch_core_if #(
    parameter int unsigned DIGITS = 4
);
    logic                  start_stop;
    logic                  clear;
    logic                  load;
    logic [DIGITS*4-1:0]   load_bcd;
    logic                  dir;
    logic                  lap;
    logic [DIGITS*4-1:0]   count_bcd;
    logic [DIGITS*4-1:0]   disp_bcd;
    logic                  running;
    logic                  frozen;
    logic                  wrap;
    logic                  expired;

    // Key side drives strobes and preload, observes count and flags.
    modport master (
        output start_stop, clear, load, load_bcd, dir, lap,
        input  count_bcd, disp_bcd, running, frozen, wrap, expired
    );

    // Core side.
    modport slave (
        input  start_stop, clear, load, load_bcd, dir, lap,
        output count_bcd, disp_bcd, running, frozen, wrap, expired
    );
endinterface

// File: rtl/stopwatch_core.sv
// Mixed-radix BCD stopwatch / countdown core with internal tick prescaler,
// preload with per-digit saturation, lap freeze and wrap/expiry pulses.
module stopwatch_core #(
    parameter int unsigned         CLK_HZ  = 50_000_000,
    parameter int unsigned         TICK_HZ = 1,
    parameter int unsigned         DIGITS  = 4,
    parameter logic [DIGITS*4-1:0] RADIX   = {4'd6, 4'd10, 4'd6, 4'd10}
) (
    input  logic            clk,
    input  logic            rst_n,
    stopwatch_core_if.slave sw
);
    localparam int unsigned DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned CW  = DIGITS * 4;
    localparam logic [PW-1:0] DIV_M1 = PW'(DIV - 1);

    logic [PW-1:0] presc_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] disp_q;
    logic          running_q;
    logic          frozen_q;
    logic          wrap_q;
    logic          expired_q;

    logic [CW-1:0] up_cnt;
    logic [CW-1:0] down_cnt;
    logic [CW-1:0] sat_cnt;
    logic          carry;
    logic          borrow;
    logic [3:0]    dig;
    logic [3:0]    mx;
    logic [3:0]    ld_dig;
    logic          tick_c;
    logic          count_zero_c;
    logic          down_zero_c;

    assign tick_c       = running_q && (presc_q == DIV_M1);
    assign count_zero_c = (count_q == '0);
    assign down_zero_c  = (down_cnt == '0);

    // Next-count candidates: ripple carry/borrow across all digits and saturated preload.
    always_comb begin
        up_cnt   = '0;
        down_cnt = '0;
        sat_cnt  = '0;
        carry    = 1'b1;
        borrow   = 1'b1;
        dig      = '0;
        mx       = '0;
        ld_dig   = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            dig    = count_q[4*i +: 4];
            mx     = RADIX[4*i +: 4] - 4'd1;
            ld_dig = sw.load_bcd[4*i +: 4];

            if (!carry) begin
                up_cnt[4*i +: 4] = dig;
            end else if (dig >= mx) begin
                up_cnt[4*i +: 4] = 4'd0;
            end else begin
                up_cnt[4*i +: 4] = dig + 4'd1;
                carry            = 1'b0;
            end

            if (!borrow) begin
                down_cnt[4*i +: 4] = dig;
            end else if (dig == 4'd0) begin
                down_cnt[4*i +: 4] = mx;
            end else begin
                down_cnt[4*i +: 4] = dig - 4'd1;
                borrow             = 1'b0;
            end

            sat_cnt[4*i +: 4] = (ld_dig > mx) ? mx : ld_dig;
        end
    end

    // Prescaler: advances only while running, phase kept across stop/resume.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else if (sw.clear || sw.load) begin
            presc_q <= '0;
        end else if (running_q) begin
            presc_q <= (presc_q == DIV_M1) ? '0 : presc_q + PW'(1);
        end
    end

    // Count, run state and one-cycle flags; clear > load > start_stop > tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= '0;
            running_q <= 1'b0;
            wrap_q    <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            wrap_q    <= 1'b0;
            expired_q <= 1'b0;
            if (sw.clear) begin
                count_q   <= '0;
                running_q <= 1'b0;
            end else if (sw.load) begin
                count_q   <= sat_cnt;
                running_q <= 1'b0;
            end else if (sw.start_stop) begin
                // A countdown from zero has nothing to do, so it never starts.
                if (!(!running_q && sw.dir && count_zero_c)) begin
                    running_q <= !running_q;
                end
            end else if (tick_c) begin
                if (!sw.dir) begin
                    count_q <= up_cnt;
                    wrap_q  <= carry;
                end else begin
                    count_q <= down_cnt;
                    if (down_zero_c) begin
                        expired_q <= 1'b1;
                        running_q <= 1'b0;
                    end
                end
            end
        end
    end

    // Lap freeze; the display copies the pre-edge count unless it is holding a lap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frozen_q <= 1'b0;
            disp_q   <= '0;
        end else begin
            if (sw.clear) begin
                frozen_q <= 1'b0;
            end else if (sw.lap) begin
                frozen_q <= !frozen_q;
            end
            if (!(frozen_q && !sw.lap && !sw.clear)) begin
                disp_q <= count_q;
            end
        end
    end

    assign sw.count_bcd = count_q;
    assign sw.disp_bcd  = disp_q;
    assign sw.running   = running_q;
    assign sw.frozen    = frozen_q;
    assign sw.wrap      = wrap_q;
    assign sw.expired   = expired_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core at DIV=10 with the default MM:SS radix.
module tb_stopwatch_core;
    logic clk;
    logic rst_n;

    int checks;
    int errors;

    stopwatch_core_if #(.DIGITS(4)) bus ();

    stopwatch_core #(
        .CLK_HZ (10),
        .TICK_HZ(1),
        .DIGITS (4),
        .RADIX  ({4'd6, 4'd10, 4'd6, 4'd10})
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .sw   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive the chosen strobes for one rising edge, return at the following negedge.
    task automatic strobe(input logic ss, input logic cl, input logic ld, input logic lp);
        bus.start_stop = ss;
        bus.clear      = cl;
        bus.load       = ld;
        bus.lap        = lp;
        @(negedge clk);
        bus.start_stop = 1'b0;
        bus.clear      = 1'b0;
        bus.load       = 1'b0;
        bus.lap        = 1'b0;
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst_n          = 1'b0;
        bus.start_stop = 1'b0;
        bus.clear      = 1'b0;
        bus.load       = 1'b0;
        bus.lap        = 1'b0;
        bus.dir        = 1'b0;
        bus.load_bcd   = 16'h0000;
        step(3);
        check("rst_count",   32'(bus.count_bcd), 32'h0);
        check("rst_disp",    32'(bus.disp_bcd),  32'h0);
        check("rst_running", 32'(bus.running),   32'h0);
        check("rst_frozen",  32'(bus.frozen),    32'h0);
        rst_n = 1'b1;
        step(2);

        // Up count and wrap from 59:58.
        bus.load_bcd = 16'h5958;
        strobe(1'b0, 1'b0, 1'b1, 1'b0);
        check("load_5958", 32'(bus.count_bcd), 32'h5958);
        strobe(1'b1, 1'b0, 1'b0, 1'b0);
        check("start_run", 32'(bus.running), 32'h1);
        step(9);
        check("pre_tick", 32'(bus.count_bcd), 32'h5958);
        step(1);
        check("tick1_5959", 32'(bus.count_bcd), 32'h5959);
        step(9);
        check("hold_5959", 32'(bus.count_bcd), 32'h5959);
        check("no_wrap_yet", 32'(bus.wrap), 32'h0);
        step(1);
        check("wrap_count", 32'(bus.count_bcd), 32'h0000);
        check("wrap_pulse", 32'(bus.wrap),      32'h1);
        check("wrap_run",   32'(bus.running),   32'h1);
        step(1);
        check("wrap_1cyc", 32'(bus.wrap), 32'h0);
        strobe(1'b0, 1'b1, 1'b0, 1'b0);
        check("clear_count", 32'(bus.count_bcd), 32'h0);
        check("clear_run",   32'(bus.running),   32'h0);

        // Saturating preload.
        bus.load_bcd = 16'h9999;
        strobe(1'b0, 1'b0, 1'b1, 1'b0);
        check("sat_9999", 32'(bus.count_bcd), 32'h5959);
        check("sat_run",  32'(bus.running),   32'h0);
        bus.load_bcd = 16'h7777;
        strobe(1'b0, 1'b0, 1'b1, 1'b0);
        check("sat_7777", 32'(bus.count_bcd), 32'h5757);

        // Countdown from 01:01 and expiry.
        bus.dir      = 1'b1;
        bus.load_bcd = 16'h0101;
        strobe(1'b0, 1'b0, 1'b1, 1'b0);
        strobe(1'b1, 1'b0, 1'b0, 1'b0);
        step(10);
        check("down_0100", 32'(bus.count_bcd), 32'h0100);
        step(10);
        check("down_0059", 32'(bus.count_bcd), 32'h0059);
        step(580);
        check("down_0001", 32'(bus.count_bcd), 32'h0001);
        check("down_noexp", 32'(bus.expired), 32'h0);
        step(10);
        check("down_0000", 32'(bus.count_bcd), 32'h0000);
        check("exp_pulse", 32'(bus.expired),   32'h1);
        check("exp_stop",  32'(bus.running),   32'h0);
        step(1);
        check("exp_1cyc", 32'(bus.expired), 32'h0);
        strobe(1'b1, 1'b0, 1'b0, 1'b0);
        check("start_at_zero", 32'(bus.running), 32'h0);
        bus.dir = 1'b0;

        // Stop/resume keeps prescaler phase.
        strobe(1'b0, 1'b1, 1'b0, 1'b0);
        strobe(1'b1, 1'b0, 1'b0, 1'b0);
        step(6);
        strobe(1'b1, 1'b0, 1'b0, 1'b0);
        check("stopped", 32'(bus.running), 32'h0);
        step(50);
        check("stop_hold", 32'(bus.count_bcd), 32'h0);
        strobe(1'b1, 1'b0, 1'b0, 1'b0);
        step(2);
        check("resume_r2", 32'(bus.count_bcd), 32'h0);
        step(1);
        check("resume_r3", 32'(bus.count_bcd), 32'h0001);

        // Lap freeze and release.
        strobe(1'b0, 1'b1, 1'b0, 1'b0);
        strobe(1'b1, 1'b0, 1'b0, 1'b0);
        step(124);
        check("lap_pre", 32'(bus.count_bcd), 32'h0012);
        strobe(1'b0, 1'b0, 1'b0, 1'b1);
        check("lap_frozen", 32'(bus.frozen),   32'h1);
        check("lap_disp",   32'(bus.disp_bcd), 32'h0012);
        step(10);
        check("lap_cnt13",  32'(bus.count_bcd), 32'h0013);
        check("lap_hold13", 32'(bus.disp_bcd),  32'h0012);
        step(10);
        check("lap_hold14", 32'(bus.disp_bcd), 32'h0012);
        strobe(1'b0, 1'b0, 1'b0, 1'b1);
        check("unlap_frozen", 32'(bus.frozen), 32'h0);
        step(1);
        check("unlap_track", 32'(bus.disp_bcd), 32'h0014);
        strobe(1'b0, 1'b0, 1'b0, 1'b1);
        check("relap_frozen", 32'(bus.frozen), 32'h1);
        strobe(1'b0, 1'b1, 1'b0, 1'b1);
        check("lapclr_frozen", 32'(bus.frozen),    32'h0);
        check("lapclr_count",  32'(bus.count_bcd), 32'h0);
        step(1);
        check("lapclr_disp", 32'(bus.disp_bcd), 32'h0);

        // Clear and start_stop coinciding with a tick.
        strobe(1'b1, 1'b0, 1'b0, 1'b0);
        step(9);
        strobe(1'b1, 1'b1, 1'b0, 1'b0);
        check("prio_count", 32'(bus.count_bcd), 32'h0);
        check("prio_run",   32'(bus.running),   32'h0);
        bus.load_bcd = 16'h0123;
        strobe(1'b1, 1'b0, 1'b1, 1'b0);
        check("prio_load",     32'(bus.count_bcd), 32'h0123);
        check("prio_load_run", 32'(bus.running),   32'h0);

        // Asynchronous reset mid-count.
        strobe(1'b1, 1'b0, 1'b0, 1'b0);
        step(15);
        strobe(1'b0, 1'b0, 1'b0, 1'b1);
        check("pre_rst_count", 32'(bus.count_bcd), 32'h0124);
        #1 rst_n = 1'b0;
        #1;
        check("arst_count",   32'(bus.count_bcd), 32'h0);
        check("arst_disp",    32'(bus.disp_bcd),  32'h0);
        check("arst_running", 32'(bus.running),   32'h0);
        check("arst_frozen",  32'(bus.frozen),    32'h0);
        check("arst_wrap",    32'(bus.wrap),      32'h0);
        check("arst_expired", 32'(bus.expired),   32'h0);
        step(2);
        rst_n = 1'b1;
        step(30);
        check("post_rst_idle", 32'(bus.count_bcd), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
